// File: rtl/text_pkg.sv
// ----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text overlay sequencer: FSM state encoding,
// character grid geometry, default blank character and a screen-id helper.
// ----------------------------------------------------------------------------
package text_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COPY    = 3'd2,
    WAIT_VB = 3'd3,
    SWAP    = 3'd4
  } state_e;

  // Character code used to blank a bank and to replace ROM terminators (0x00).
  localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;

  // Character grid: 32 columns x 8 rows, one bank = 256 cells.
  localparam int COLS        = 32;
  localparam int ROWS        = 8;
  localparam int ADDR_W      = 8;
  localparam int BANK_ADDR_W = 9;
  localparam int CNT_W       = 9;
  localparam int ID_W        = 2;
  localparam int MSG_ADDR_W  = 7;
  localparam int CLEAR_LAST  = COLS * ROWS - 1;

  // Out-of-range screen ids fall back to the blank screen (id 0).
  function automatic logic [ID_W-1:0] sanitize_id(input logic [ID_W-1:0] id,
                                                  input int num_screens);
    if (int'(id) >= num_screens) begin
      return '0;
    end
    return id;
  endfunction

endpackage

// File: rtl/vblank_edge_det.sv
// ----------------------------------------------------------------------------
// vblank_edge_det
// Registers a level signal (e.g. vertical blank) every cycle and produces a
// single-cycle pulse on its rising edge. The pulse is combinational from the
// live input and the registered copy, so it is valid in the same cycle the
// level first reads high.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (clears the registered level)
//   level_i  in   level to watch
//   rise_o   out  level_i & ~registered level_i
// ----------------------------------------------------------------------------
module vblank_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/text_screen_ctrl.sv
// ----------------------------------------------------------------------------
// text_screen_ctrl
// Text overlay sequencer. On a screen request it blanks the hidden character
// bank, copies one message from the message ROM into a fixed row of that
// bank, then flips the visible bank at the next vertical-blank rising edge so
// the draw pipeline never sees a half-written screen.
//
// States:
//   IDLE    | waiting for a request; ready is high
//   CLEAR   | 256 cycles writing BLANK_CHAR to every cell of the hidden bank
//   COPY    | MSG_LEN+1 cycles streaming ROM characters into row MSG_ROW
//   WAIT_VB | no writes, waiting for a vblnk rising edge
//   SWAP    | one cycle: flip buf_sel, update text_enable, raise done
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   screen_req    request valid (sampled only while ready)
//   screen_id     requested message, 0 = blank screen
//   ready         combinational, high in IDLE (and while reset is held)
//   done          one-cycle pulse when the new bank becomes visible
//   vblnk         vertical blank level from the video timing
//   msg_addr      {id, idx} to message ROM; msg_char returns one cycle later
//   msg_char      ROM data
//   buf_we/buf_waddr/buf_wdata  character RAM write port, {bank, col, row}
//   buf_sel       bank currently read by the draw pipeline
//   text_enable   overlay visible
// ----------------------------------------------------------------------------
module text_screen_ctrl
  import text_pkg::*;
#(
  parameter int         NUM_SCREENS = 4,
  parameter int         MSG_LEN     = 32,
  parameter int         MSG_ROW     = 3,
  parameter logic [7:0] BLANK_CHAR  = BLANK_CHAR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   screen_req,
  input  logic [ID_W-1:0]        screen_id,
  output logic                   ready,
  output logic                   done,
  input  logic                   vblnk,
  output logic [MSG_ADDR_W-1:0]  msg_addr,
  input  logic [7:0]             msg_char,
  output logic                   buf_we,
  output logic [BANK_ADDR_W-1:0] buf_waddr,
  output logic [7:0]             buf_wdata,
  output logic                   buf_sel,
  output logic                   text_enable
);

  localparam logic [CNT_W-1:0] CLEAR_END = CNT_W'(CLEAR_LAST);
  localparam logic [CNT_W-1:0] COPY_END  = CNT_W'(MSG_LEN);
  localparam logic [2:0]       ROW_FIELD = 3'(MSG_ROW);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ID_W-1:0]         id_q;
  logic [ID_W-1:0]         id_d;
  logic                    buf_sel_q;
  logic                    text_en_q;
  logic                    buf_we_q;
  logic [BANK_ADDR_W-1:0]  buf_waddr_q;
  logic [7:0]              buf_wdata_q;
  logic [MSG_ADDR_W-1:0]   msg_addr_q;
  logic                    done_q;
  logic                    vb_rise;

  // Column index of the character arriving on msg_char (requested last cycle)
  // and of the next ROM address to present.
  logic [4:0]              col_prev;
  logic [4:0]              col_next;
  logic [7:0]              copy_char;

  vblank_edge_det u_vb_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (vblnk),
    .rise_o  (vb_rise)
  );

  assign id_d      = sanitize_id(screen_id, NUM_SCREENS);
  assign col_prev  = 5'(cnt_q - 9'd1);
  assign col_next  = 5'(cnt_q + 9'd1);
  assign copy_char = (msg_char == 8'h00) ? BLANK_CHAR : msg_char;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      buf_sel_q   <= 1'b0;
      text_en_q   <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
      msg_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      buf_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (screen_req) begin
            id_q    <= id_d;
            cnt_q   <= '0;
            state_q <= CLEAR;
          end
        end

        CLEAR: begin
          buf_we_q    <= 1'b1;
          buf_waddr_q <= {~buf_sel_q, cnt_q[ADDR_W-1:0]};
          buf_wdata_q <= BLANK_CHAR;
          if (cnt_q == CLEAR_END) begin
            cnt_q <= '0;
            if (id_q != '0) begin
              // Present the first ROM address now so its data is on
              // msg_char during COPY cnt=1.
              msg_addr_q <= {id_q, 5'd0};
              state_q    <= COPY;
            end else begin
              state_q <= WAIT_VB;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end

        COPY: begin
          // msg_addr reads {id_q, cnt} while in COPY with that cnt.
          if (cnt_q + 9'd1 < COPY_END) begin
            msg_addr_q <= {id_q, col_next};
          end
          if (cnt_q != '0) begin
            buf_we_q    <= 1'b1;
            buf_waddr_q <= {~buf_sel_q, col_prev, ROW_FIELD};
            buf_wdata_q <= copy_char;
          end
          if (cnt_q == COPY_END) begin
            cnt_q   <= '0;
            state_q <= WAIT_VB;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end

        WAIT_VB: begin
          if (vb_rise) begin
            state_q <= SWAP;
          end
        end

        SWAP: begin
          buf_sel_q <= ~buf_sel_q;
          text_en_q <= (id_q != '0);
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Reads high while reset is held, before the state register has settled.
  assign ready       = rst | (state_q == IDLE);
  assign done        = done_q;
  assign msg_addr    = msg_addr_q;
  assign buf_we      = buf_we_q;
  assign buf_waddr   = buf_waddr_q;
  assign buf_wdata   = buf_wdata_q;
  assign buf_sel     = buf_sel_q;
  assign text_enable = text_en_q;

endmodule
